// File: rtl/rc4_decrypt_loop_pkg.sv
// rc4_pkg: shared definitions for the RC4 key-search datapath.
//   - loop3_state_e : state encoding of the decrypt loop (loop 3)
//   - MSG_LEN       : bytes in the encrypted message
//   - S_SIZE        : entries in the S memory
//   - KEY_W/KEY_MAX : key width and highest key searched (shared with check_char)
package rc4_pkg;

  localparam int MSG_LEN = 32;
  localparam int S_SIZE  = 256;
  localparam int KEY_W   = 24;
  localparam logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RD_SI = 4'd1,
    ST_W_SI  = 4'd2,
    ST_RD_SJ = 4'd3,
    ST_W_SJ  = 4'd4,
    ST_WR_I  = 4'd5,
    ST_WR_J  = 4'd6,
    ST_RD_F  = 4'd7,
    ST_W_F   = 4'd8,
    ST_XOR   = 4'd9,
    ST_OFFER = 4'd10,
    ST_NEXT  = 4'd11,
    ST_FIN   = 4'd12
  } loop3_state_e;

endpackage

// File: rtl/rc4_decrypt_loop_if.sv
// rc4_decrypt_loop_if: memory bus between the decrypt loop and its memories.
//   S memory     : s_addr, s_wdata, s_wren (loop -> mem), s_rdata (mem -> loop)
//   encrypted ROM: e_addr (loop -> rom), e_rdata (rom -> loop)
//   decrypted RAM: d_addr, d_wdata, d_wren (loop -> ram)
// All memories register their address; read data follows one cycle later.
// modport master: the decrypt loop.  modport slave: the memory side.
interface rc4_decrypt_loop_if #(
  parameter int ADDR_W = 5
) ();

  logic [7:0]        s_addr;
  logic [7:0]        s_wdata;
  logic              s_wren;
  logic [7:0]        s_rdata;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_rdata;
  logic [ADDR_W-1:0] d_addr;
  logic [7:0]        d_wdata;
  logic              d_wren;

  modport master (
    output s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren,
    input  s_rdata, e_rdata
  );

  modport slave (
    input  s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren,
    output s_rdata, e_rdata
  );

endinterface

// File: rtl/rc4_decrypt_loop.sv
// rc4_decrypt_loop: loop 3 of the RC4 key search. Runs the PRGA over the
// shuffled S memory, XORs each keystream byte with the encrypted ROM, writes
// the plaintext to the decrypted RAM and offers each byte to check_char.
//
// Ports:
//   clok, resetm        clock, synchronous active-high reset
//   start               pulse from loops 1-2: S is shuffled, begin a pass
//   start_over          abort request from check_char (level, top priority)
//   compared_char       ack from check_char for the offered byte
//   mem                 memory bus (rc4_decrypt_loop_if.master)
//   new_char            plaintext byte valid on char_recieved
//   char_recieved       plaintext byte
//   char_count          current k (reaches MSG_LEN only in FIN)
//   busy, done          pass in progress / pass completed
//   dbg_cycles          busy-cycle counter, present only with LOOP3_CYCLE_CNT_EN
//
// Optional feature macro: LOOP3_CYCLE_CNT_EN
//
// Every output is driven straight from a flop: the next-state logic computes
// the value each output must carry in the state being entered.
module rc4_decrypt_loop #(
  parameter int MSG_LEN = rc4_pkg::MSG_LEN,
  parameter int ADDR_W  = 5
) (
  input  logic                clok,
  input  logic                resetm,
  input  logic                start,
  input  logic                start_over,
  input  logic                compared_char,
  rc4_decrypt_loop_if.master  mem,
  output logic                new_char,
  output logic [7:0]          char_recieved,
  output logic [5:0]          char_count,
  output logic                busy,
`ifdef LOOP3_CYCLE_CNT_EN
  output logic                done,
  output logic [15:0]         dbg_cycles
`else
  output logic                done
`endif
);

  import rc4_pkg::*;

  localparam logic [5:0] MSG_LEN_C = 6'(MSG_LEN);

  loop3_state_e      state_r, state_s;
  logic [7:0]        i_r, i_s;
  logic [7:0]        j_r, j_s;
  logic [7:0]        si_r, si_s;
  logic [7:0]        sj_r, sj_s;
  logic [5:0]        k_r, k_s;
  logic [7:0]        s_addr_r, s_addr_s;
  logic [7:0]        s_wdata_r, s_wdata_s;
  logic              s_wren_r, s_wren_s;
  logic [ADDR_W-1:0] e_addr_r, e_addr_s;
  logic [ADDR_W-1:0] d_addr_r, d_addr_s;
  logic [7:0]        d_wdata_r, d_wdata_s;
  logic              d_wren_r, d_wren_s;
  logic              new_char_r, new_char_s;
  logic [7:0]        char_r, char_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              start_ok_s;

  // start is honoured only when no pass is running (IDLE or FIN)
  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_FIN));

  // Next-state and next-output logic of the per-byte PRGA sequence
  always_comb begin
    state_s    = state_r;
    i_s        = i_r;
    j_s        = j_r;
    si_s       = si_r;
    sj_s       = sj_r;
    k_s        = k_r;
    s_addr_s   = s_addr_r;
    s_wdata_s  = s_wdata_r;
    s_wren_s   = 1'b0;
    e_addr_s   = e_addr_r;
    d_addr_s   = d_addr_r;
    d_wdata_s  = d_wdata_r;
    d_wren_s   = 1'b0;
    new_char_s = new_char_r;
    char_s     = char_r;
    busy_s     = busy_r;
    done_s     = done_r;

    if (start_over) begin
      state_s    = ST_IDLE;
      new_char_s = 1'b0;
      busy_s     = 1'b0;
      done_s     = 1'b0;
      i_s        = 8'd0;
      j_s        = 8'd0;
      k_s        = 6'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_FIN: begin
          if (start_ok_s) begin
            // i restarts at 0 and RD_SI pre-increments it, so enter with i=1
            state_s  = ST_RD_SI;
            i_s      = 8'd1;
            s_addr_s = 8'd1;
            j_s      = 8'd0;
            k_s      = 6'd0;
            done_s   = 1'b0;
            busy_s   = 1'b1;
          end else begin
            state_s = state_r;
          end
        end
        ST_RD_SI: state_s = ST_W_SI;
        ST_W_SI: begin
          // S[i] arrives now; fold it into j and fetch S[j]
          state_s  = ST_RD_SJ;
          si_s     = mem.s_rdata;
          j_s      = j_r + mem.s_rdata;
          s_addr_s = j_r + mem.s_rdata;
        end
        ST_RD_SJ: state_s = ST_W_SJ;
        ST_W_SJ: begin
          // S[j] arrives now; swap starts by writing it to S[i]
          state_s   = ST_WR_I;
          sj_s      = mem.s_rdata;
          s_addr_s  = i_r;
          s_wdata_s = mem.s_rdata;
          s_wren_s  = 1'b1;
        end
        ST_WR_I: begin
          state_s   = ST_WR_J;
          s_addr_s  = j_r;
          s_wdata_s = si_r;
          s_wren_s  = 1'b1;
        end
        ST_WR_J: begin
          state_s  = ST_RD_F;
          s_addr_s = si_r + sj_r;
          e_addr_s = ADDR_W'(k_r);
        end
        ST_RD_F: state_s = ST_W_F;
        ST_W_F: begin
          state_s   = ST_XOR;
          char_s    = mem.s_rdata ^ mem.e_rdata;
          d_addr_s  = ADDR_W'(k_r);
          d_wdata_s = mem.s_rdata ^ mem.e_rdata;
          d_wren_s  = 1'b1;
        end
        ST_XOR: begin
          state_s    = ST_OFFER;
          new_char_s = 1'b1;
        end
        ST_OFFER: begin
          if (compared_char) begin
            state_s    = ST_NEXT;
            new_char_s = 1'b0;
          end else begin
            state_s = ST_OFFER;
          end
        end
        ST_NEXT: begin
          k_s = k_r + 6'd1;
          if ((k_r + 6'd1) == MSG_LEN_C) begin
            state_s = ST_FIN;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s  = ST_RD_SI;
            i_s      = i_r + 8'd1;
            s_addr_s = i_r + 8'd1;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          new_char_s = 1'b0;
          busy_s     = 1'b0;
          done_s     = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clok) begin
    if (resetm) begin
      state_r    <= ST_IDLE;
      i_r        <= 8'd0;
      j_r        <= 8'd0;
      si_r       <= 8'd0;
      sj_r       <= 8'd0;
      k_r        <= 6'd0;
      s_addr_r   <= 8'd0;
      s_wdata_r  <= 8'd0;
      s_wren_r   <= 1'b0;
      e_addr_r   <= '0;
      d_addr_r   <= '0;
      d_wdata_r  <= 8'd0;
      d_wren_r   <= 1'b0;
      new_char_r <= 1'b0;
      char_r     <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      i_r        <= i_s;
      j_r        <= j_s;
      si_r       <= si_s;
      sj_r       <= sj_s;
      k_r        <= k_s;
      s_addr_r   <= s_addr_s;
      s_wdata_r  <= s_wdata_s;
      s_wren_r   <= s_wren_s;
      e_addr_r   <= e_addr_s;
      d_addr_r   <= d_addr_s;
      d_wdata_r  <= d_wdata_s;
      d_wren_r   <= d_wren_s;
      new_char_r <= new_char_s;
      char_r     <= char_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

`ifdef LOOP3_CYCLE_CNT_EN
  logic [15:0] cyc_r;

  // Busy-cycle counter: saturating, frozen outside a pass
  always_ff @(posedge clok) begin
    if (resetm) begin
      cyc_r <= 16'd0;
    end else if (start_over || start_ok_s) begin
      cyc_r <= 16'd0;
    end else if (busy_r && (cyc_r != 16'hFFFF)) begin
      cyc_r <= cyc_r + 16'd1;
    end else begin
      cyc_r <= cyc_r;
    end
  end

  assign dbg_cycles = cyc_r;
`endif

  assign mem.s_addr    = s_addr_r;
  assign mem.s_wdata   = s_wdata_r;
  assign mem.s_wren    = s_wren_r;
  assign mem.e_addr    = e_addr_r;
  assign mem.d_addr    = d_addr_r;
  assign mem.d_wdata   = d_wdata_r;
  assign mem.d_wren    = d_wren_r;
  assign new_char      = new_char_r;
  assign char_recieved = char_r;
  assign char_count    = k_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: doc/rc4_decrypt_loop.md
Name: rc4_decrypt_loop

Overview:
- Loop 3 of the RC4 key-search datapath.
- Runs the PRGA over the initialised/shuffled S memory, XORs each keystream byte with the encrypted-message ROM, and writes the plaintext to decrypted RAM.
- Offers each plaintext byte to check_char through a new_char/compared_char handshake; a start_over from check_char aborts the pass.
- Sits between the S-memory/ROM/RAM instances and check_char. Loops 1–2 (init, shuffle) trigger it via start.

Parameters:
- MSG_LEN, 32, bytes in encrypted message; char_count reaches MSG_LEN at end.
- ADDR_W, 5, encrypted ROM / decrypted RAM address width.

Ports:
- clok  in  1  system clock
- resetm  in  1  synchronous, active-high reset
- start  in  1  pulse: S memory shuffled, begin pass
- start_over  in  1  abort request from check_char (level, sampled every cycle)
- compared_char  in  1  ack from check_char: current char accepted
- s_addr  out  8  S memory address
- s_wdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- s_rdata  in  8  S memory read data
- e_addr  out  ADDR_W  encrypted ROM address
- e_rdata  in  8  encrypted ROM data
- d_addr  out  ADDR_W  decrypted RAM address
- d_wdata  out  8  decrypted RAM data
- d_wren  out  1  decrypted RAM write enable
- new_char  out  1  plaintext byte valid on char_recieved
- char_recieved  out  8  plaintext byte
- char_count  out  6  current k (0..MSG_LEN)
- busy  out  1  pass in progress
- done  out  1  pass completed, held until start/start_over

Behaviour:
- Reset: all outputs 0; i=j=k=0; state IDLE.
- Memories have registered address. Read data is valid one cycle after the address is driven, so each read costs one WAIT state.
- All index arithmetic is 8-bit mod-256 wraparound; k is 6-bit.
- FSM per byte:
  - IDLE: on start, clear i/j/k/done, set busy, go to RD_SI.
  - RD_SI: i<=i+1; s_addr=i+1.
  - W_SI: wait one cycle.
  - RD_SJ: latch si=s_rdata; j<=j+si; s_addr=j+si.
  - W_SJ: wait one cycle.
  - WR_I: latch sj; s_addr=i, s_wdata=sj, s_wren=1.
  - WR_J: s_addr=j, s_wdata=si, s_wren=1.
  - RD_F: s_addr=si+sj (8-bit sum); e_addr=k.
  - W_F: wait one cycle.
  - XOR: char_recieved<=s_rdata^e_rdata; d_addr=k, d_wdata=result, d_wren=1.
  - OFFER: new_char=1, held until compared_char.
  - NEXT: new_char<=0; k<=k+1. If k+1==MSG_LEN go to FIN, else go to RD_SI.
  - FIN: char_count=MSG_LEN, done=1, busy=0. Hold until start (restart) or start_over.
- Latency: 10 cycles from RD_SI to first new_char assertion, plus handshake wait.
- Write enables are single-cycle pulses. Only one of s_wren and d_wren is high in any cycle.
- start_over has priority over every state, including FIN:
  - Next cycle: state=IDLE, new_char=0, all wren=0, busy=0, done=0, i=j=k=0, char_count=0.
  - Wait for the next start; S memory is re-initialised by loops 1–2.
- start_over and compared_char in the same cycle: start_over wins.
- start while busy is ignored.
- compared_char outside OFFER is ignored.
- char_count mirrors k continuously; check_char's char_count<=32 test relies on reaching exactly MSG_LEN only in FIN.

Optional Feature:
- Macro LOOP3_CYCLE_CNT_EN.
- Defined: adds output dbg_cycles[15:0], counting clok cycles while busy.
  - Cleared on start, start_over and reset.
  - Saturates at 16'hFFFF.
  - Holds its value in FIN.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package rc4_pkg:
  - loop3 state enum;
  - MSG_LEN and S_SIZE=256 constants;
  - key width 24 and key_max constant, shared with check_char.
- No sub-module is needed. Optionally split out rc4_offer_hs (new_char/compared_char/start_over handshake flop) for reuse by loops 1–2.

Test Plan:
- Reset with resetm=1 for 2 cycles -> all outputs 0, state IDLE; start ignored while resetm=1.
- Identity S (S[n]=n), e_rdata=8'h00 all k, start -> k=0: i=1, j=1, f=S[2]=2, char_recieved=8'h02, d_wren at d_addr=0, new_char held until compared_char.
- Known key 24'h000249 vectors (golden model S after shuffle) with compared_char acked 1 cycle after each new_char -> 32 plaintext bytes match model, done=1, char_count=32.
- Delay compared_char 5 cycles -> new_char and char_recieved stable throughout, no extra S/RAM writes.
- start_over at k=7 during W_SJ -> next cycle IDLE, char_count=0, no wren; subsequent start restarts at k=0.
- j wraparound: S[1]=8'hF0, j=8'h20 -> j=8'h10, s_addr=8'h10; f index (si+sj) wraps mod 256.
